// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} and holds ready_o until the requester drops start_i.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               sgn_q, sgn_n;
    logic               a_msb_q, a_msb_n;
    logic               b_msb_q, b_msb_n;
    logic [WIDTH-1:0]   dvsr_q, dvsr_n;
    logic [WIDTH-1:0]   rem_q, rem_n;
    logic [WIDTH-1:0]   quo_q, quo_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] abs_val(input logic sg, input logic [WIDTH-1:0] x);
        return (sg && x[WIDTH-1]) ? WIDTH'(~x + WIDTH'(1)) : x;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sgn_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sgn_q    <= sgn_n;
            a_msb_q  <= a_msb_n;
            b_msb_q  <= b_msb_n;
            dvsr_q   <= dvsr_n;
            rem_q    <= rem_n;
            quo_q    <= quo_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    // Next-state, restoring step and sign correction
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sgn_n    = sgn_q;
        a_msb_n  = a_msb_q;
        b_msb_n  = b_msb_q;
        dvsr_n   = dvsr_q;
        rem_n    = rem_q;
        quo_n    = quo_q;
        result_n = result_o;
        ready_n  = ready_o;

        // Partial remainder needs one extra bit so divisors with MSB set compare correctly
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        quo_fix = (sgn_q && (a_msb_q ^ b_msb_q)) ? WIDTH'(~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = (sgn_q && a_msb_q) ? WIDTH'(~rem_q + WIDTH'(1)) : rem_q;

        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    sgn_n   = signed_div_i;
                    a_msb_n = opdata1_i[WIDTH-1];
                    b_msb_n = opdata2_i[WIDTH-1];
                    dvsr_n  = abs_val(signed_div_i, opdata2_i);
                    if (opdata2_i == '0) begin
                        state_n = BYZERO;
                    end else begin
                        state_n = ON;
                        cnt_n   = '0;
                        rem_n   = '0;
                        quo_n   = abs_val(signed_div_i, opdata1_i);
                    end
                end
            end
            BYZERO: begin
                state_n  = END;
                result_n = '0;
                ready_n  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_n = IDLE;
                    ready_n = 1'b0;
                end else if (cnt != CNT_W'(WIDTH)) begin
                    quo_n = {quo_q[WIDTH-2:0], 1'b0};
                    if (rem_sh >= {1'b0, dvsr_q}) begin
                        rem_n    = WIDTH'(rem_sh - {1'b0, dvsr_q});
                        quo_n[0] = 1'b1;
                    end else begin
                        rem_n = WIDTH'(rem_sh);
                    end
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    result_n = {rem_fix, quo_fix};
                    ready_n  = 1'b1;
                    state_n  = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: table of divides plus annul/reset/back-to-back sequences.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges from now until ready_o rises; 0 means it never rose within the budget
    task automatic wait_ready(input int budget, output int edge_n);
        edge_n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (i == 1) begin
                opdata1_i = 32'hDEAD_BEEF;
                opdata2_i = 32'h0000_0000;
            end
            if (ready_o) begin
                edge_n = i;
                break;
            end
        end
    endtask

    task automatic run_div(input string name, input vec_t v);
        int e;
        signed_div_i = v.sg;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        start_i      = 1'b1;
        wait_ready(60, e);
        check({name, "_latency"}, 64'(e), 64'(v.lat));
        check({name, "_result"}, result_o, v.exp);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check({name, "_hold"}, {result_o[62:0], ready_o}, {v.exp[62:0], 1'b1});
        end
        start_i = 1'b0;
        tick();
        check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({name, "_drop_result"}, result_o, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int e;
        logic seen;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34, 0});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  64'hFFFFFFFF_FFFFFFFD, 34, 0});
        vecs.push_back('{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 34, 0});
        vecs.push_back('{1'b0, 32'd5,          32'd0,          64'h00000000_00000000,  2, 1});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 34, 0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 34, 0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  64'hFFFFFFFE_00000000, 34, 0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  64'h00000000_FFFFFFFF, 34, 0});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 34, 0});
        vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 34, 0});

        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);

        foreach (vecs[i]) run_div($sformatf("vec%0d", i), vecs[i]);

        // annul mid-divide, then reset mid-divide: neither may produce ready_o
        seen = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            seen |= ready_o;
            if (i == 9) annul_i = 1'b1;
            if (i == 10) begin
                annul_i = 1'b0;
                start_i = 1'b0;
            end
        end
        check("annul_no_ready", 64'(seen), 64'd0);

        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            seen |= ready_o;
            if (i == 19) begin
                rst = 1'b1;
                start_i = 1'b0;
            end
            if (i == 20) rst = 1'b0;
        end
        check("reset_mid_no_ready", 64'(seen), 64'd0);
        run_div("after_abort_9_3", '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 0});

        // annul in IDLE blocks the start until it is released
        signed_div_i = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd6;
        start_i = 1'b1;
        annul_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_annul_blocks", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        wait_ready(60, e);
        check("idle_annul_latency", 64'(e), 64'd34);
        check("idle_annul_result", result_o, 64'h00000002_00000008);
        start_i = 1'b0;
        tick();

        // start_i dropped during ON is ignored: the result still appears for one cycle
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        e = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 5) start_i = 1'b0;
            if (ready_o && e == 0) begin
                e = i;
                check("drop_in_on_result", result_o, 64'h00000002_0000000E);
            end
        end
        check("drop_in_on_latency", 64'(e), 64'd34);
        check("drop_in_on_idle", 64'(ready_o), 64'd0);

        // back-to-back: hold 3 edges, drop one edge, re-raise with new operands
        run_div("b2b_first", '{1'b0, 32'd77, 32'd10, 64'h00000007_00000007, 34, 3});
        run_div("b2b_second", '{1'b1, 32'hFFFF_FFB3, 32'd10, 64'hFFFFFFF9_FFFFFFF9, 34, 3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
